// File: rtl/arbiter4_ctrl.sv
// Four-requester arbiter: registered one-hot grant, hold-time limit, forced-release pulse.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 3 > 2 > 1 > 0.
module arbiter4_ctrl #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] last_q, last_d;

    logic [1:0] win_id;
    logic       win_vld;
    logic [1:0] idx;
    logic       hold_hit;
    logic       early_rel;

    // Winner search; the highest-priority candidate is visited last so it overrides.
    always_comb begin
        win_id  = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 4; k >= 1; k--) begin
            idx = last_q - 2'(k);
            if (req[idx]) begin
                win_id  = idx;
                win_vld = 1'b1;
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            if (req[idx]) begin
                win_id  = idx;
                win_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        hold_hit  = (cnt_q == HOLD_LIM);
        early_rel = done | ~req[gnt_id_q] | ~en;

        case (state_q)
            IDLE: begin
                if (en && win_vld) begin
                    state_d  = BUSY;
                    gnt_d    = 4'b0001 << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
                    cnt_d    = 8'd1;
                    last_d   = win_id;
                end
            end
            BUSY: begin
                if (early_rel || hold_hit) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'd0;
                    busy_d    = 1'b0;
                    cnt_d     = 8'd0;
                    // Pulse only when the hold limit is the sole reason for release.
                    timeout_d = hold_hit && !early_rel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'd0;
                busy_d   = 1'b0;
                cnt_d    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
            last_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter4_ctrl.sv
// Bench for arbiter4_ctrl: owner/hold-count model checked every cycle plus directed literal checks.
module tb_arbiter4_ctrl;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst, en, done;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    arbiter4_ctrl #(.HOLD_MAX(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Model state: owner index (-1 = none), cycles held, last winner, timeout pulse.
    int m_owner = -1;
    int m_hold  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [3:0] r, input int last);
        int p;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            p = (last + 4 - k) % 4;
            if (r[p]) return p;
        end
`else
        for (int k = 3; k >= 0; k--) begin
            p = k;
            if (r[p]) return p;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        bit other_rel;
        if (rst) begin
            m_owner = -1; m_hold = 0; m_last = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (en && req != 4'b0000) begin
                m_owner = pick(req, m_last);
                m_hold  = 1;
                m_last  = m_owner;
            end
        end else begin
            other_rel = done || !req[m_owner] || !en;
            if (other_rel || m_hold == HOLD) begin
                m_to    = !other_rel;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("model_gnt",     int'(gnt),     (m_owner < 0) ? 0 : (1 << m_owner));
        chk("model_gnt_id",  int'(gnt_id),  (m_owner < 0) ? 0 : m_owner);
        chk("model_busy",    int'(busy),    (m_owner < 0) ? 0 : 1);
        chk("model_timeout", int'(timeout), int'(m_to));
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic et);
        chk({name, "_gnt"},     int'(gnt),     int'(eg));
        chk({name, "_gnt_id"},  int'(gnt_id),  int'(eid));
        chk({name, "_busy"},    int'(busy),    int'(eb));
        chk({name, "_timeout"}, int'(timeout), int'(et));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 4'b1111; done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            lit("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        rst = 1'b0; en = 1'b0; req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            lit("en_low", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick; lit("en_rise", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick; lit("drop0", 4'b0000, 2'd0, 1'b0, 1'b0);

        req = 4'b1010;
        tick; lit("prio_first", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick; lit("prio_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick;
`ifdef ARB_ROUND_ROBIN_EN
        lit("prio_second", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        lit("prio_second", 4'b1000, 2'd3, 1'b1, 1'b0);
`endif

        req = 4'b0000;
        tick; tick;
        req = 4'b0100;
        tick; lit("hold_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 2; i <= HOLD; i++) begin
            tick; lit("hold_cn", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        tick; lit("timeout_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick; lit("timeout_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        req = 4'b0000;
        tick; tick;
        req = 4'b0010;
        tick; lit("own_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick; lit("own_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0010;
        tick; lit("own_grant2", 4'b0010, 2'd1, 1'b1, 1'b0);
        en = 1'b0;
        tick; lit("en_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        en = 1'b1; req = 4'b0000;
        tick;

        req = 4'b1000;
        tick; lit("rm_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick;
        done = 1'b0; req = 4'b0100;
        tick; lit("rm_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        tick; lit("rm_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b1111;
        tick; lit("rm_after", 4'b1000, 2'd3, 1'b1, 1'b0);

        req = 4'b0000;
        tick;
        req = 4'b0100;
        tick;
        for (int i = 2; i <= HOLD; i++) tick;
        done = 1'b1;
        tick; lit("limit_with_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick;
        done = 1'b1; req = 4'b0000;
        tick; lit("done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
